// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg
//   Elastic register slice between two pipeline stages. Carries a control
//   vector and a payload with valid/ready handshakes on both sides. It
//   supports a synchronous squash (Flush) and counts back-pressure cycles
//   in a saturating counter.
//
//   Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry.
//   With the skid entry, In_Ready is a flop and has no combinational path
//   from Out_Ready. Without it the stage holds a single entry and
//   In_Ready = !Out_Valid || Out_Ready. When Out_Ready stays high, both
//   builds behave the same on every cycle.
//
// Ports
//   CLOCK       rising-edge clock
//   RESET       asynchronous, active-high reset
//   In_Valid    upstream beat present
//   In_Ready    stage can accept a beat this cycle
//   In_Ctrl     upstream control bits   [CTRL_W]
//   In_Data     upstream payload        [DATA_W]
//   Flush       squash held and incoming beats at the next edge
//   Out_Valid   downstream beat present
//   Out_Ready   downstream accepts the beat
//   Out_Ctrl    registered control bits, all-zero while Out_Valid=0
//   Out_Data    registered payload, holds its last value when idle
//   StallCount  saturating count of cycles with Out_Valid && !Out_Ready
module pipeline_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_FULL      = 2'd1,
    S_FULL_SKID = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              accept, emit;
  logic              load_in;     // output register takes the incoming beat
  logic              clr_ctrl;    // output becomes a bubble: zero the control bits
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CNT_W-1:0]  stall_q;

`ifdef PIPE_STAGE_SKID_EN
  logic              load_skid;   // output register takes the skid entry
  logic              skid_wr;     // skid entry captures the incoming beat
  logic              in_ready_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;

  assign In_Ready = in_ready_q;
`else
  // A single entry can refill in the same cycle it drains.
  assign In_Ready = !Out_Valid || Out_Ready;
`endif

  assign Out_Valid  = (state != S_EMPTY);
  assign Out_Ctrl   = out_ctrl_q;
  assign Out_Data   = out_data_q;
  assign StallCount = stall_q;

  assign accept = In_Valid && In_Ready;
  assign emit   = Out_Valid && Out_Ready;

  // Next-state and register-load decode. Flush overrides every transition.
  always_comb begin
    state_nxt = state;
    load_in   = 1'b0;
    clr_ctrl  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    load_skid = 1'b0;
    skid_wr   = 1'b0;
`endif
    if (Flush) begin
      state_nxt = S_EMPTY;
      clr_ctrl  = 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state_nxt = S_FULL;
            load_in   = 1'b1;
          end
        end
        S_FULL: begin
          if (emit && accept) begin
            load_in = 1'b1;
          end else if (emit) begin
            state_nxt = S_EMPTY;
            clr_ctrl  = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
          end else if (accept) begin
            // The output is blocked, so the new beat waits in the skid entry.
            state_nxt = S_FULL_SKID;
            skid_wr   = 1'b1;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        S_FULL_SKID: begin
          // In_Ready is low here, so only draining is possible.
          if (emit) begin
            state_nxt = S_FULL;
            load_skid = 1'b1;
          end
        end
`endif
        default: begin
          state_nxt = S_EMPTY;
          clr_ctrl  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= S_EMPTY;
    else       state <= state_nxt;
  end

  // Output register. Data is left alone on bubbles; only control is zeroed.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      out_ctrl_q <= '0;
      out_data_q <= '0;
    end else if (load_in) begin
      out_ctrl_q <= In_Ctrl;
      out_data_q <= In_Data;
`ifdef PIPE_STAGE_SKID_EN
    end else if (load_skid) begin
      out_ctrl_q <= skid_ctrl_q;
      out_data_q <= skid_data_q;
`endif
    end else if (clr_ctrl) begin
      out_ctrl_q <= '0;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (Flush) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (skid_wr) begin
      skid_ctrl_q <= In_Ctrl;
      skid_data_q <= In_Data;
    end
  end

  // In_Ready is registered from the next state, so it never depends on
  // Out_Ready combinationally.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) in_ready_q <= 1'b1;
    else       in_ready_q <= (state_nxt != S_FULL_SKID);
  end
`endif

  // Back-pressure counter. Flush does not clear it; only RESET does.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      stall_q <= '0;
    end else if (Out_Valid && !Out_Ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg. It keeps a queue-based model of the held
// beats and compares every DUT output against that model on each falling
// edge. Literal expectations pin the model at chosen points. A second
// instance with a 3-bit counter exercises counter saturation.
module tb_pipeline_stage_reg;
  localparam int DW = 32;
  localparam int CW = 5;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b0;
  logic          In_Valid = 1'b0;
  logic          Flush = 1'b0;
  logic          Out_Ready = 1'b0;
  logic [CW-1:0] In_Ctrl = '0;
  logic [DW-1:0] In_Data = '0;
  logic          In_Ready, Out_Valid;
  logic [CW-1:0] Out_Ctrl;
  logic [DW-1:0] Out_Data;
  logic [15:0]   StallCount;
  logic          In_Ready3, Out_Valid3;
  logic [CW-1:0] Out_Ctrl3;
  logic [DW-1:0] Out_Data3;
  logic [2:0]    StallCount3;

  pipeline_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Ctrl(In_Ctrl), .In_Data(In_Data), .Flush(Flush), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Out_Ctrl(Out_Ctrl), .Out_Data(Out_Data),
    .StallCount(StallCount));

  pipeline_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3)) dut3 (
    .CLOCK(CLOCK), .RESET(RESET), .In_Valid(In_Valid), .In_Ready(In_Ready3),
    .In_Ctrl(In_Ctrl), .In_Data(In_Data), .Flush(Flush), .Out_Valid(Out_Valid3),
    .Out_Ready(Out_Ready), .Out_Ctrl(Out_Ctrl3), .Out_Data(Out_Data3),
    .StallCount(StallCount3));

  always #5 CLOCK = ~CLOCK;

  // ---------------- behavioural model ----------------
  logic [CW-1:0] qc[$];
  logic [DW-1:0] qd[$];
  logic [DW-1:0] m_last;
  longint        m_stall;

  function automatic bit m_valid();
    return qc.size() != 0;
  endfunction
  function automatic logic [CW-1:0] m_ctrl();
    return (qc.size() != 0) ? qc[0] : '0;
  endfunction
  function automatic logic [DW-1:0] m_data();
    return (qd.size() != 0) ? qd[0] : m_last;
  endfunction
  function automatic bit m_rdy();
    if (SKID) return qc.size() < 2;
    return (qc.size() == 0) || Out_Ready;
  endfunction
  function automatic longint m_sat(input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (m_stall > lim) ? lim : m_stall;
  endfunction

  task automatic model_reset();
    qc.delete(); qd.delete();
    m_last = '0;
    m_stall = 0;
  endtask

  // One clock edge of the reference: emit, count the stall, then either
  // squash or accept.
  task automatic model_edge();
    bit e, a;
    e = m_valid() && Out_Ready;
    a = In_Valid && m_rdy();
    if (m_valid() && !Out_Ready) m_stall++;
    if (e) begin
      void'(qc.pop_front());
      void'(qd.pop_front());
    end
    if (Flush) begin
      qc.delete(); qd.delete();
    end else if (a) begin
      qc.push_back(In_Ctrl);
      qd.push_back(In_Data);
    end
    if (qd.size() != 0) m_last = qd[0];
  endtask

  // ---------------- literal pins on the model ----------------
  bit            run = 1'b0;
  bit            pin_en = 1'b0, pd_en = 1'b0, pr_en = 1'b0, ps_en = 1'b0;
  bit            pv = 1'b0, pr = 1'b0;
  logic [CW-1:0] pc = '0;
  logic [DW-1:0] pd = '0;
  longint        ps = 0, ps3 = 0;

  // ---------------- compare process ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLOCK) begin
    if (run) begin
      chk("out_valid",   64'(Out_Valid),   64'(m_valid()));
      chk("out_ctrl",    64'(Out_Ctrl),    64'(m_ctrl()));
      chk("out_data",    64'(Out_Data),    64'(m_data()));
      chk("in_ready",    64'(In_Ready),    64'(m_rdy()));
      chk("stall_cnt",   64'(StallCount),  64'(m_sat(16)));
      chk("stall_cnt3",  64'(StallCount3), 64'(m_sat(3)));
      chk("out_valid3",  64'(Out_Valid3),  64'(m_valid()));
      if (pin_en) begin
        chk("pin_valid", 64'(m_valid()), 64'(pv));
        chk("pin_ctrl",  64'(m_ctrl()),  64'(pc));
        if (pd_en) chk("pin_data",   64'(m_data()),  64'(pd));
        if (pr_en) chk("pin_ready",  64'(m_rdy()),   64'(pr));
        if (ps_en) begin
          chk("pin_stall",  64'(m_sat(16)), 64'(ps));
          chk("pin_stall3", 64'(m_sat(3)),  64'(ps3));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr_pins();
    pin_en = 0; pd_en = 0; pr_en = 0; ps_en = 0;
  endtask

  task automatic pin(input bit v, input logic [CW-1:0] c);
    pin_en = 1; pv = v; pc = c;
  endtask

  task automatic step(input bit iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input bit ordy, input bit fl);
    @(negedge CLOCK); #1;
    clr_pins();
    In_Valid = iv; In_Ctrl = c; In_Data = d; Out_Ready = ordy; Flush = fl;
    @(posedge CLOCK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLOCK); #1;
    clr_pins();
    In_Valid = 0; Flush = 0; Out_Ready = 0;
    RESET = 1;
    model_reset();
    @(posedge CLOCK); #1;
    RESET = 0;
  endtask

  // Reset pulse that starts and ends between two rising edges.
  task automatic pulse_reset();
    RESET = 1;
    model_reset();
    #2;
    RESET = 0;
  endtask

  initial begin
    model_reset();
    do_reset();
    run = 1;
    // Reset state
    pin(0, '0); pd_en = 1; pd = '0; pr_en = 1; pr = 1; ps_en = 1; ps = 0; ps3 = 0;

    // Single beat, one-cycle latency, then bubble with zero control
    step(1, 5'b10101, 32'h0000_1234, 1, 0);
    pin(1, 5'b10101); pd_en = 1; pd = 32'h1234; pr_en = 1; pr = 1;
    step(0, '0, '0, 1, 0);
    pin(0, '0); pd_en = 1; pd = 32'h1234;

    // Back-to-back stream 1..8
    for (int i = 1; i <= 8; i++) begin
      step(1, CW'(i), DW'(i), 1, 0);
      pin(1, CW'(i)); pd_en = 1; pd = DW'(i); pr_en = 1; pr = 1;
    end
    step(0, '0, '0, 1, 0);
    pin(0, '0);

    // Back-pressure with a second beat waiting
    step(1, 5'h3, 32'hA, 0, 0);
    pin(1, 5'h3); pd_en = 1; pd = 32'hA; pr_en = 1; pr = SKID;
    step(1, 5'h4, 32'hB, 0, 0);
    pin(1, 5'h3); pd_en = 1; pd = 32'hA; pr_en = 1; pr = 0;
    step(0, '0, '0, 1, 0);
    if (SKID) begin pin(1, 5'h4); pd_en = 1; pd = 32'hB; end
    else      begin pin(0, '0);   pd_en = 1; pd = 32'hA; end
    step(0, '0, '0, 1, 0);
    pin(0, '0);

    // Stall counter: 12 blocked cycles, 16-bit and 3-bit instances
    do_reset();
    step(1, 5'h7, 32'h55, 0, 0);
    pin(1, 5'h7); ps_en = 1; ps = 0; ps3 = 0;
    for (int k = 1; k <= 12; k++) begin
      step(0, '0, '0, 0, 0);
      if (k == 7)  begin pin(1, 5'h7); ps_en = 1; ps = 7;  ps3 = 7; end
      if (k == 10) begin pin(1, 5'h7); ps_en = 1; ps = 10; ps3 = 7; end
      if (k == 12) begin pin(1, 5'h7); ps_en = 1; ps = 12; ps3 = 7; end
    end
    step(0, '0, '0, 1, 0);

    // Flush with held beats and an incoming beat
    do_reset();
    step(1, 5'h1, 32'hA, 0, 0);
    step(1, 5'h2, 32'hB, 0, 0);
    step(1, 5'h4, 32'hC, 0, 1);
    pin(0, '0); pr_en = 1; pr = 1; ps_en = 1; ps = 2; ps3 = 2;
    step(0, '0, '0, 1, 0);
    pin(0, '0); ps_en = 1; ps = 2; ps3 = 2;

    // Asynchronous reset between edges while full
    step(1, 5'h9, 32'h77, 0, 0);
    step(0, '0, '0, 0, 0);
    pulse_reset();
    pin(0, '0); pd_en = 1; pd = '0; ps_en = 1; ps = 0; ps3 = 0;
    step(1, 5'h6, 32'h99, 1, 0);
    pin(1, 5'h6); pd_en = 1; pd = 32'h99;

    // Randomised traffic with changing back-pressure, flushes and resets
    for (int n = 0; n < 2500; n++) begin
      int rdy_pct;
      rdy_pct = ((n / 250) % 3 == 0) ? 90 : (((n / 250) % 3 == 1) ? 50 : 15);
      step($urandom_range(0, 3) != 0, CW'($urandom), $urandom,
           $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 399) == 0) pulse_reset();
    end

    @(negedge CLOCK); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, payload width (ALU result, store data, PC, etc. concatenated by the instantiator).
REQ-002 Parameter CTRL_W, default 5, control-bit width (RegWriteEN, Mem2RegSEL, MemWriteEN, Branch, ZeroFlag, ...).
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 CLOCK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 In_Valid  input  1  upstream beat present.
REQ-007 In_Ready  output  1  stage can accept a beat this cycle.
REQ-008 In_Ctrl  input  CTRL_W  upstream control bits.
REQ-009 In_Data  input  DATA_W  upstream payload.
REQ-010 Flush  input  1  synchronous squash of all held and incoming beats.
REQ-011 Out_Valid  output  1  downstream beat present.
REQ-012 Out_Ready  input  1  downstream accepts the beat.
REQ-013 Out_Ctrl  output  CTRL_W  registered control bits.
REQ-014 Out_Data  output  DATA_W  registered payload.
REQ-015 StallCount  output  CNT_W  saturating back-pressure cycle count.

Function
REQ-016 Accept = In_Valid && In_Ready; Emit = Out_Valid && Out_Ready; beats leave in arrival order, none duplicated or lost except by Flush.
REQ-017 Latency: beat accepted at edge N into an empty stage appears on Out_* after edge N (1 cycle).
REQ-018 States: EMPTY, FULL, and FULL_SKID (skid build only); Out_Valid = (state != EMPTY).
REQ-019 EMPTY: Accept -> FULL; else stay.
REQ-020 FULL: Emit && Accept -> FULL with new beat; Emit only -> EMPTY; Accept without Emit -> FULL_SKID (skid build only); otherwise hold Out_Ctrl/Out_Data unchanged.
REQ-021 FULL_SKID: Emit -> FULL, skid entry moves to output register; no Accept possible (In_Ready=0).
REQ-022 Out_Ctrl SHALL be all-zero whenever Out_Valid=0 (bubble never asserts write enables); Out_Data is don't-care but holds its last value.
REQ-023 Flush SHALL have priority over all transitions: next state EMPTY, Out_Ctrl and skid entry cleared, beat presented in the same cycle dropped.
REQ-024 StallCount SHALL increment by 1 each cycle with Out_Valid=1 and Out_Ready=0, saturate at 2^CNT_W-1, and be unaffected by Flush.

Reset
REQ-025 RESET=1 SHALL immediately force state EMPTY, Out_Valid=0, Out_Ctrl=0, Out_Data=0, skid entry cleared, StallCount=0, independent of CLOCK.
REQ-026 Reset asserted mid-transfer SHALL discard all held beats; first Accept after deassertion is the first beat emitted.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN defined: second (skid) entry present; In_Ready = (state != FULL_SKID), driven from a register with no combinational path from Out_Ready.
REQ-028 Macro PIPE_STAGE_SKID_EN undefined: single entry, FULL_SKID unreachable; In_Ready = !Out_Valid || Out_Ready (combinational).
REQ-029 Both builds SHALL be cycle-identical when Out_Ready is held at 1.

Verification
REQ-030 Reset, then In_Valid=1, In_Ctrl=5'b10101, In_Data=0x0000_1234, Out_Ready=1 for one cycle -> Out_Valid=1, Out_Ctrl=5'b10101, Out_Data=0x1234 after next edge; Out_Valid=0, Out_Ctrl=0 one cycle later.
REQ-031 Stream 0x1..0x8 with Out_Ready=1 -> one beat per cycle, outputs 0x1..0x8 in order, In_Ready constantly 1.
REQ-032 Skid build: stage FULL with 0xA, Out_Ready=0, present 0xB -> accepted, In_Ready=0 next cycle; then Out_Ready=1 -> 0xA then 0xB emitted on consecutive cycles; non-skid build: 0xB not accepted while Out_Ready=0.
REQ-033 Out_Ready=0 for 10 cycles with FULL stage -> StallCount=10; CNT_W=3 with 12 stall cycles -> StallCount=7.
REQ-034 Flush asserted while FULL_SKID and In_Valid=1 -> next cycle Out_Valid=0, Out_Ctrl=0, In_Ready=1, none of the three beats ever emitted, StallCount unchanged.
REQ-035 RESET pulsed between clock edges while FULL -> Out_Valid, Out_Ctrl, Out_Data, StallCount read 0 before the next rising edge.
